// File: rtl/hilo_pkg.sv
// Shared funct codes and controller state encoding for the HI/LO register block.
package hilo_pkg;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  function automatic logic is_read(input logic [5:0] funct);
    return (funct == MFHI) || (funct == MFLO);
  endfunction

endpackage

// File: rtl/hilo_seq_ctrl.sv
// Multiply sequencer: IDLE/MUL FSM, step counter and the MULTU re-arm flag.
module hilo_seq_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] signal_i,
  output logic       busy_o,
  output logic       mul_start_o,
  output logic       capture_o
);

  localparam logic [5:0] LAST_STEP = 6'(MULT_CYCLES);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       arm_q, arm_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      arm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q | (signal_i != MULTU);
    case (state_q)
      IDLE: begin
        if (arm_q && (signal_i == MULTU)) begin
          state_d = MUL;
          cnt_d   = '0;
          arm_d   = 1'b0;
        end
      end
      MUL: begin
        if (cnt_q == LAST_STEP) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == MUL);
    mul_start_o = (state_q == MUL) && (cnt_q == '0);
    capture_o   = (state_q == MUL) && (cnt_q == LAST_STEP);
  end

endmodule

// File: rtl/hilo_reg.sv
// HI/LO register file with registered MFHI/MFLO reads and a multiply sequencer.
// Optional macro HILO_MTHI_EN enables the MTHI/MTLO writes in IDLE.
module hilo_reg
  import hilo_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic [63:0] dataIn,
  output logic        mulStart,
  output logic        busy,
  output logic [31:0] dataOut,
  output logic        dataValid
);

  logic        capture;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_hi_q, pend_hi_d;
  logic        rd_req, rd_hi, serve_hi;

  hilo_seq_ctrl #(
    .MULT_CYCLES(MULT_CYCLES)
  ) u_seq_ctrl (
    .clk        (clk),
    .rst_n      (reset),
    .signal_i   (Signal),
    .busy_o     (busy),
    .mul_start_o(mulStart),
    .capture_o  (capture)
  );

  assign rd_req   = is_read(Signal);
  assign rd_hi    = (Signal == MFHI);
  // A read arriving on the capture cycle is the latest request and wins.
  assign serve_hi = rd_req ? rd_hi : pend_hi_q;

  always_comb begin
    hi_d         = hi_q;
    lo_d         = lo_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_hi_d    = pend_hi_q;
    if (capture) begin
      hi_d         = dataIn[63:32];
      lo_d         = dataIn[31:0];
      pend_valid_d = 1'b0;
      if (rd_req || pend_valid_q) begin
        data_valid_d = 1'b1;
        data_out_d   = serve_hi ? dataIn[63:32] : dataIn[31:0];
      end
    end else if (busy) begin
      if (rd_req) begin
        pend_valid_d = 1'b1;
        pend_hi_d    = rd_hi;
      end
    end else begin
      if (rd_req) begin
        data_valid_d = 1'b1;
        data_out_d   = rd_hi ? hi_q : lo_q;
      end
`ifdef HILO_MTHI_EN
      if (Signal == MTHI) begin
        hi_d = dataIn[31:0];
      end else if (Signal == MTLO) begin
        lo_d = dataIn[31:0];
      end
`endif
    end
  end

  // NOTE: HI/LO are two flat registers, not a memory array, so they take a
  // reset value like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q         <= '0;
      lo_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_hi_q    <= 1'b0;
    end else begin
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_hi_q    <= pend_hi_d;
    end
  end

  assign dataOut   = data_out_q;
  assign dataValid = data_valid_q;

endmodule

// File: doc/hilo_reg.md
HILO_REG -- requirements
Module: hilo_reg

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 32, meaning number of multiplier step cycles before the product is captured.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Signal  input  6  funct code: MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010.
REQ-005 SHALL have port dataIn  input  64  product from the multiplier stage.
REQ-006 SHALL have port mulStart  output  1  one-cycle pulse that restarts the multiplier stage.
REQ-007 SHALL have port busy  output  1  high while a multiply is in flight.
REQ-008 SHALL have port dataOut  output  32  registered HI or LO read result.
REQ-009 SHALL have port dataValid  output  1  one-cycle pulse marking dataOut as a new read result.

Function
REQ-010 SHALL hold internal 32-bit registers HI and LO, a state register {IDLE, MUL}, a 6-bit step counter, an arm flag and one pending-read slot.
REQ-011 SHALL accept MULTU at a clock edge only in IDLE with arm=1, then enter MUL, clear the counter and clear arm.
REQ-012 SHALL set arm=1 at any edge where Signal != MULTU, so a held MULTU level starts exactly one multiply.
REQ-013 SHALL drive mulStart=1 for exactly the first cycle in MUL and 0 otherwise.
REQ-014 SHALL increment the counter each cycle in MUL and, at the edge where counter==MULT_CYCLES, load HI=dataIn[63:32] and LO=dataIn[31:0] and return to IDLE.
REQ-015 SHALL give capture latency MULT_CYCLES+1 edges after the accepting edge; busy=1 exactly in MUL.
REQ-016 SHALL, on MFHI/MFLO in IDLE, load dataOut with HI/LO and pulse dataValid at the next edge (1-cycle latency).
REQ-017 SHALL, on MFHI/MFLO in MUL, record it in the pending slot (latest request wins) and serve it at the capture edge using the new dataIn value.
REQ-018 SHALL ignore MULTU received in MUL (counter not restarted, arm unaffected except by REQ-012).
REQ-019 SHALL leave dataOut unchanged when dataValid=0.
REQ-020 SHALL treat all other Signal codes as no-ops.

Reset
REQ-021 SHALL, when reset=0, immediately force HI=0, LO=0, dataOut=0, dataValid=0, mulStart=0, busy=0, state=IDLE, counter=0, arm=1, pending slot empty.
REQ-022 SHALL abort an in-flight multiply on reset without updating HI/LO.

Configuration
REQ-023 SHALL, with macro HILO_MTHI_EN defined, decode MTHI=6'b010001 and MTLO=6'b010011 in IDLE, writing dataIn[31:0] to HI or LO at the next edge.
REQ-024 SHALL, without HILO_MTHI_EN, treat MTHI/MTLO as no-ops.
REQ-025 SHALL ignore MTHI/MTLO received in MUL in both configurations.

Structure
REQ-026 SHALL take funct constants (MULTU, MFHI, MFLO, MTHI, MTLO) and the state enum from the shared package hilo_pkg.
REQ-027 SHALL place the FSM, counter and arm logic in one sub-module hilo_seq_ctrl; the HI/LO storage and read mux stay in hilo_reg.

Verification
REQ-028 SHALL cover: MULTU held 40 cycles, dataIn=64'h0000_0001_0000_000F -> mulStart for 1 cycle, busy for 33 cycles, then MFHI gives dataOut=32'h1 and MFLO gives 32'hF, each with one dataValid pulse.
REQ-029 SHALL cover: MFLO issued 5 cycles into MUL, dataIn=64'hDEAD_BEEF_1234_5678 at capture -> dataOut=32'h1234_5678 and dataValid at the capture edge.
REQ-030 SHALL cover: reset=0 at counter=10 -> busy=0 at once, HI=LO=0, and the following MFHI returns 0.
REQ-031 SHALL cover: MULTU pulsed again at counter=3 -> capture still at the original edge and only one mulStart.
REQ-032 SHALL cover: MULTU held across capture -> no second multiply until Signal drops and returns to MULTU.
REQ-033 SHALL cover: with HILO_MTHI_EN, MTHI dataIn[31:0]=32'hCAFE_0001 then MFHI -> 32'hCAFE_0001; without the macro, MFHI returns the prior HI.
